data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the core's data-memory interface: accepts one load/store
//   request at a time over a valid/ready handshake, inserts WAIT_CYCLES wait
//   states, performs a byte-strobed word access on an internal RAM and returns
//   read data / error over a second valid/ready channel. Replaces the zero-latency
//   data memory so the core's stall path and error path can be exercised.
// PARAMETERS
//   DEPTH_WORDS  256  number of 32-bit words in the RAM (power of 2, >= 4)
//   BASE_ADDR    0    byte address of word 0 (DEPTH_WORDS*4-aligned)
//   WAIT_CYCLES  2    wait states between acceptance and RAM access (0..15)
// PORTS
//   clk        in   1   clock, all logic on rising edge
//   reset      in   1   synchronous, active-low reset
//   req_valid  in   1   core presents a request
//   req_ready  out  1   responder can accept a request
//   req_addr   in   32  byte address
//   req_write  in   1   1 = store, 0 = load
//   req_wstrb  in   4   byte enables for store (bit i -> wdata[8i+7:8i]); ignored on load
//   req_wdata  in   32  store data
//   rsp_valid  out  1   response available
//   rsp_ready  in   1   core consumes response
//   rsp_rdata  out  32  load data; 0 for stores and errored requests
//   rsp_err    out  1   1 = misaligned (addr[1:0]!=0) or outside [BASE, BASE+4*DEPTH)
// BEHAVIOUR
//   - Reset (reset==0 at an edge): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0, wait counter=0. RAM contents are NOT cleared. Reset mid-operation
//     aborts the transaction; a store not yet at ACCESS is never committed.
//   - FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE; one outstanding transaction.
//   - IDLE: req_ready=1. Edge with req_valid&&req_ready = acceptance edge E0: latch
//     addr/write/wstrb/wdata, compute err; go WAIT with counter=WAIT_CYCLES, or
//     directly ACCESS if WAIT_CYCLES==0. req_ready=0 in every state except IDLE.
//   - WAIT: counter decrements each edge; at counter==1 next state ACCESS.
//   - ACCESS (1 cycle): if !err && write, RAM bytes with wstrb=1 updated at the
//     leaving edge; other bytes unchanged; wstrb==0 store is a legal no-op.
//     If !err && !write, rsp_rdata <= RAM[word]. If err, no RAM access, rdata <= 0.
//     rsp_err <= err. Next RESP.
//   - Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after E0 for every
//     request, including errored ones (uniform timing).
//   - RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready sampled 1;
//     at that edge rsp_valid<=0, state IDLE. rsp_ready asserted early (before RESP)
//     has no effect. No new request accepted in the RESP->IDLE edge (back-to-back
//     throughput = WAIT_CYCLES+3 cycles min).
//   - Word index = (addr - BASE_ADDR) >> 2, log2(DEPTH_WORDS) bits; range check on
//     full 32-bit subtraction, no wrap-around aliasing (addr < BASE_ADDR -> err).
//   - req_* inputs ignored outside IDLE; changes there never affect the in-flight op.
//   - Load from an address never written returns RAM power-up/init content (bench
//     preloads); X-propagation on rdata is allowed only in that case.
// STRUCTURE
//   - Shared package/header riscv_mem_defs: state encodings (IDLE=0, WAIT=1,
//     ACCESS=2, RESP=3), WSTRB_ALL=4'hF, data/address width constants.
//   - Sub-module dm_sram_array: single-port synchronous RAM, DEPTH_WORDS x 32,
//     4 byte write enables, registered read; FSM/handshake/range check stay here.
// TESTING
//   - W=2: after reset, store addr 0x8 wdata 0xDEADBEEF wstrb F -> rsp_valid 3 edges
//     after accept, rsp_err=0, rsp_rdata=0; load 0x8 -> rdata 0xDEADBEEF.
//   - Byte strobes: word 0x10 = 0x11223344, store wdata 0xAABBCCDD wstrb 4'b0101 ->
//     load returns 0x11BB33DD.
//   - Errors: load 0x6 (misaligned) and load BASE+4*DEPTH -> rsp_err=1, rdata=0,
//     same latency; RAM unchanged (re-read word 0x4 returns prior value).
//   - Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable,
//     req_ready=0 throughout; rsp_ready=1 -> IDLE next edge, req_ready=1.
//   - Reset mid-op: accept store to 0x20 (0xCAFEF00D), pull reset low during WAIT ->
//     all outputs at reset values; load 0x20 returns old content.
//   - WAIT_CYCLES=0 build: rsp_valid 1 edge after accept; stream 4 loads with
//     req_valid held high -> each accepted only in IDLE, responses in order.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;

  // Full-word byte-enable pattern
  localparam logic [STRB_W-1:0] WSTRB_ALL = '1;

  // Transaction phases; encodings are fixed so other blocks can decode them
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dm_state_t;

endpackage

// File: rtl/data_mem_responder_sram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: write commits at the enabled edge; read data appears one edge after rd_en.
// Backpressure: none; rdata holds until the next rd_en/rd_clr or reset.
module dm_sram_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [STRB_W-1:0] wr_be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane writes; storage is deliberately not touched by reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wr_be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register: cleared for stores/errors so the response carries zero data
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states, byte-strobed RAM access.
// Latency: rsp_valid rises WAIT_CYCLES+1 edges after acceptance, errored requests included.
// Backpressure: response held stable until rsp_ready; req_ready only high while idle.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH_WORDS * 4);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  dm_state_t         state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] req_off;
  logic              req_err;
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_write;
  logic              lat_err;
  logic [STRB_W-1:0] lat_wstrb;
  logic [DATA_W-1:0] lat_wdata;
  logic              in_access;
  logic              ram_rd_en;
  logic              ram_rd_clr;
  logic [STRB_W-1:0] ram_wr_be;

  // Addresses below BASE_ADDR wrap to an offset >= SPAN (BASE is SPAN-aligned),
  // so a single unsigned compare rejects both sides of the window without aliasing.
  assign req_off = req_addr - BASE_ADDR;
  assign req_err = (req_off[1:0] != 2'b00) || (req_off >= SPAN);

  // RAM is only touched during ACCESS, and never at an edge where reset is asserted
  assign in_access  = (state == ST_ACCESS) && reset;
  assign ram_wr_be  = (in_access && lat_write && !lat_err) ? lat_wstrb : '0;
  assign ram_rd_en  = in_access && !lat_write && !lat_err;
  assign ram_rd_clr = in_access && (lat_write || lat_err);

  // Transaction sequencer: accept, count wait states, access, hold response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wstrb <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_idx   <= req_off[IDX_W+1:2];
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_wstrb <= req_wstrb;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACCESS;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_err   <= lat_err;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dm_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (ram_rd_en),
    .rd_clr(ram_rd_clr),
    .wr_be (ram_wr_be),
    .idx   (lat_idx),
    .wdata (lat_wdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two builds (2 wait states at base 0, 0 wait states at base 0x1000).
// Latency: n/a.
// Backpressure: n/a.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int          W0  = 2;
  localparam int          W1  = 0;
  localparam int          D0  = 256;
  localparam int          D1  = 64;
  localparam logic [31:0] B0  = 32'h0000_0000;
  localparam logic [31:0] B1  = 32'h0000_1000;
  localparam int          TMO = 40;

  logic        clk;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_write [2];
  logic [3:0]  req_wstrb [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(D0), .BASE_ADDR(B0), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_write(req_write[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(D1), .BASE_ADDR(B1), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_write(req_write[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic longint base_of(input int k);
    return (k == 0) ? longint'(B0) : longint'(B1);
  endfunction

  function automatic longint depth_of(input int k);
    return (k == 0) ? longint'(D0) : longint'(D1);
  endfunction

  // ---------------- reference model ----------------
  // One transaction at a time: a response is due wait+1 edges after acceptance,
  // stores land in the model memory when that response becomes due, and a reset
  // before then discards them.
  logic [31:0] mmem   [2][256];
  bit   [3:0]  mknown [2][256];
  bit          m_init [2];
  bit          m_busy [2];
  bit          m_vld  [2];
  bit          m_clean[2];
  bit          m_rdk  [2];
  int          m_age  [2];
  logic [31:0] m_rd   [2];
  logic        m_err  [2];
  bit          p_wr   [2];
  int          p_idx  [2];
  logic [3:0]  p_strb [2];
  logic [31:0] p_dat  [2];

  task automatic model_edge(input int k);
    longint a, lo, hi;
    int     idx;
    logic [31:0] ad;
    if (!reset[k]) begin
      m_init[k] = 1; m_busy[k] = 0; m_vld[k] = 0; m_clean[k] = 1;
      m_rd[k] = 32'h0; m_err[k] = 1'b0; m_rdk[k] = 1; p_wr[k] = 0;
    end else if (m_init[k]) begin
      if (!m_busy[k]) begin
        if (req_valid[k]) begin
          m_busy[k] = 1; m_age[k] = 0; m_clean[k] = 0; p_wr[k] = 0;
          ad = req_addr[k];
          a  = longint'(ad);
          lo = base_of(k);
          hi = lo + 4 * depth_of(k);
          m_err[k] = (ad[1:0] != 2'b00) || (a < lo) || (a >= hi);
          m_rd[k]  = 32'h0;
          m_rdk[k] = 1;
          if (!m_err[k]) begin
            idx = int'((a - lo) / 4);
            if (req_write[k]) begin
              p_wr[k] = 1; p_idx[k] = idx; p_strb[k] = req_wstrb[k]; p_dat[k] = req_wdata[k];
            end else begin
              m_rd[k]  = mmem[k][idx];
              m_rdk[k] = (mknown[k][idx] == 4'hF);
            end
          end
        end
      end else if (m_vld[k]) begin
        if (rsp_ready[k]) begin
          m_busy[k] = 0; m_vld[k] = 0;
        end
      end else begin
        m_age[k]++;
        if (m_age[k] == wc(k) + 1) begin
          m_vld[k] = 1;
          if (p_wr[k]) begin
            for (int b = 0; b < 4; b++) begin
              if (p_strb[k][b]) begin
                mmem[k][p_idx[k]][8*b +: 8] = p_dat[k][8*b +: 8];
                mknown[k][p_idx[k]][b] = 1'b1;
              end
            end
          end
          p_wr[k] = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
  end

  // Compare process: every negedge once each instance has seen reset
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_init[k]) begin
        chk($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(!m_busy[k]));
        chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(m_vld[k]));
        if (m_vld[k] || m_clean[k]) begin
          chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err[k]), 32'(m_err[k]));
          if (m_rdk[k]) chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], m_rd[k]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int k, input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input bit early,
                       output logic [31:0] rd, output logic er, output int lat);
    int t;
    t = 0;
    while (!req_ready[k] && t < TMO) begin @(negedge clk); t++; end
    chk("req_ready before request", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_addr[k] = a; req_write[k] = w; req_wstrb[k] = s; req_wdata[k] = d;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request fields: the in-flight operation must not see them
    req_valid[k] = 1'b0; req_addr[k] = ~a & 32'hFFFF_FFFC; req_write[k] = ~w;
    req_wstrb[k] = WSTRB_ALL; req_wdata[k] = ~d;
    if (early) rsp_ready[k] = 1'b1;
    lat = 0;
    while (!rsp_valid[k] && lat < TMO) begin @(negedge clk); lat++; end
    chk("rsp_valid within bound", 32'(rsp_valid[k]), 32'd1);
    rd = rsp_rdata[k];
    er = rsp_err[k];
  endtask

  task automatic consume(input int k);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  task automatic txn(input int k, input logic [31:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er,
                     input string name);
    logic [31:0] rd;
    logic er;
    int lat;
    issue(k, a, w, s, d, 1'b0, rd, er, lat);
    consume(k);
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " err"}, 32'(er), 32'(exp_er));
    chk({name, " latency"}, 32'(lat), 32'(wc(k) + 1));
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, t;
    time t_acc, t_prev;
    logic [31:0] stream_exp [4];

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = '0; req_write[k] = 1'b0;
      req_wstrb[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset req_ready", 32'(req_ready[k]), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset rsp_rdata", rsp_rdata[k], 32'd0);
      chk("reset rsp_err", 32'(rsp_err[k]), 32'd0);
      reset[k] = 1'b1;
    end
    @(negedge clk);

    // ---- 2 wait states, base 0, 256 words ----
    txn(0, 32'h8,  1, WSTRB_ALL, 32'hDEADBEEF, 32'h0,        0, "store 0x8");
    txn(0, 32'h8,  0, 4'h0,      32'h0,        32'hDEADBEEF, 0, "load 0x8");
    txn(0, 32'h10, 1, WSTRB_ALL, 32'h11223344, 32'h0,        0, "store 0x10");
    txn(0, 32'h10, 1, 4'b0101,   32'hAABBCCDD, 32'h0,        0, "strobed store 0x10");
    txn(0, 32'h10, 0, 4'h0,      32'h0,        32'h11BB33DD, 0, "load 0x10");
    txn(0, 32'h4,  1, WSTRB_ALL, 32'h5A5A0004, 32'h0,        0, "store 0x4");
    txn(0, 32'h0,  1, WSTRB_ALL, 32'h0BADC0DE, 32'h0,        0, "store 0x0");
    txn(0, 32'h6,  0, 4'h0,      32'h0,        32'h0,        1, "misaligned load");
    txn(0, 32'h400, 0, 4'h0,     32'h0,        32'h0,        1, "load past end");
    txn(0, 32'h400, 1, WSTRB_ALL, 32'hFFFFFFFF, 32'h0,       1, "store past end");
    txn(0, 32'hFFFF_FFFC, 1, WSTRB_ALL, 32'h77777777, 32'h0, 1, "store top addr");
    txn(0, 32'h4,  0, 4'h0,      32'h0,        32'h5A5A0004, 0, "reload 0x4");
    txn(0, 32'h0,  0, 4'h0,      32'h0,        32'h0BADC0DE, 0, "reload 0x0");
    txn(0, 32'h8,  1, 4'h0,      32'h12345678, 32'h0,        0, "empty-strobe store");
    txn(0, 32'h8,  0, 4'h0,      32'h0,        32'hDEADBEEF, 0, "load after empty store");

    // Backpressure: response held for 5 cycles
    issue(0, 32'h8, 0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
      chk("bp req_ready", 32'(req_ready[0]), 32'd0);
    end
    consume(0);
    chk("bp released req_ready", 32'(req_ready[0]), 32'd1);
    chk("bp released rsp_valid", 32'(rsp_valid[0]), 32'd0);

    // rsp_ready raised before the response exists
    issue(0, 32'h10, 0, 4'h0, 32'h0, 1'b1, rd, er, lat);
    consume(0);
    chk("early-ready rdata", rd, 32'h11BB33DD);
    chk("early-ready latency", 32'(lat), 32'd3);

    // Reset during wait states discards the store
    txn(0, 32'h20, 1, WSTRB_ALL, 32'h01234567, 32'h0, 0, "store 0x20");
    t = 0;
    while (!req_ready[0] && t < TMO) begin @(negedge clk); t++; end
    chk("doomed store ready", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b1; req_addr[0] = 32'h20; req_write[0] = 1'b1;
    req_wstrb[0] = WSTRB_ALL; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midop reset req_ready", 32'(req_ready[0]), 32'd1);
    chk("midop reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midop reset rsp_rdata", rsp_rdata[0], 32'd0);
    chk("midop reset rsp_err", 32'(rsp_err[0]), 32'd0);
    reset[0] = 1'b1;
    @(negedge clk);
    txn(0, 32'h20, 0, 4'h0, 32'h0, 32'h01234567, 0, "load 0x20 after reset");

    // ---- zero wait states, base 0x1000, 64 words ----
    txn(1, 32'h1000, 1, WSTRB_ALL, 32'h10001000, 32'h0, 0, "w0 store 0x1000");
    txn(1, 32'h1004, 1, WSTRB_ALL, 32'h20002000, 32'h0, 0, "w0 store 0x1004");
    txn(1, 32'h1008, 1, WSTRB_ALL, 32'h30003000, 32'h0, 0, "w0 store 0x1008");
    txn(1, 32'h100C, 1, WSTRB_ALL, 32'h40004000, 32'h0, 0, "w0 store 0x100C");
    txn(1, 32'h0FFC, 0, 4'h0,      32'h0,        32'h0, 1, "w0 load below base");
    txn(1, 32'h1100, 0, 4'h0,      32'h0,        32'h0, 1, "w0 load past end");
    txn(1, 32'h10FC, 1, WSTRB_ALL, 32'h5EED0000, 32'h0, 0, "w0 store last word");
    txn(1, 32'h10FC, 0, 4'h0,      32'h0, 32'h5EED0000, 0, "w0 load last word");
    txn(1, 32'h1002, 1, WSTRB_ALL, 32'hFFFFFFFF, 32'h0, 1, "w0 misaligned store");
    txn(1, 32'h1000, 0, 4'h0,      32'h0, 32'h10001000, 0, "w0 reload 0x1000");

    // Streaming loads with req_valid held high throughout
    stream_exp[0] = 32'h10001000; stream_exp[1] = 32'h20002000;
    stream_exp[2] = 32'h30003000; stream_exp[3] = 32'h40004000;
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_wstrb[1] = 4'h0; req_wdata[1] = 32'h0;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      req_addr[1] = B1 + 32'(4 * i);
      t = 0;
      while (!req_ready[1] && t < TMO) begin @(negedge clk); t++; end
      chk("stream ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk);
      t_acc = $time;
      if (i > 0) chk("stream accept spacing", 32'((t_acc - t_prev) / 10), 32'd3);
      t_prev = t_acc;
      @(negedge clk);
      t = 0;
      while (!rsp_valid[1] && t < TMO) begin @(negedge clk); t++; end
      chk("stream rsp_valid", 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("stream rdata %0d", i), rsp_rdata[1], stream_exp[i]);
      chk("stream latency", 32'(t), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
